// File: rtl/bus_slave_sel_pkg.sv
// bus_slave_sel_pkg -- shared definitions for the bus slave selector.
//   Holds the FSM state encoding, the active-low ENABLE_/DISABLE_ levels and
//   the default slave count / index width used by bus_slave_sel.
package bus_slave_sel_pkg;

   localparam int SLAVE_NUM_DEF = 8;
   localparam int INDEX_W_DEF   = 3;

   // Active-low signal levels used on mReq_, mRdy_, sCS_ and sRdy_.
   localparam logic ENABLE_  = 1'b0;
   localparam logic DISABLE_ = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEL  = 2'd1,
      ST_DONE = 2'd2
   } bus_state_e;

endpackage

// File: rtl/bus_sel_timer.sv
// bus_sel_timer -- SEL-state timeout counter for bus_slave_sel.
//   clk      : system clock, rising edge
//   reset    : synchronous active-high reset
//   run_i    : high while the selector is in SEL; low clears the count
//   expire_o : high in the SEL cycle that is the TIMEOUT_CYC-th one
module bus_sel_timer #(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic run_i,
   output logic expire_o
);

   logic [15:0] cnt_q, cnt_d;

   // Count is 0 in the first SEL cycle, so cycle k sees k-1.
   always_comb begin
      cnt_d = '0;
      if (run_i) cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign expire_o = run_i && (cnt_q == 16'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/bus_slave_sel.sv
// bus_slave_sel -- decodes a master word address into one of SLAVE_NUM
// active-low chip selects and returns a one-cycle completion pulse.
//   clk    : system clock, rising edge      reset : synchronous, active high
//   mReq_  : master request (active low)    mAddr : master word address
//   mRdy_  : transfer-complete pulse (low)  mErr  : error, valid with mRdy_
//   sCS_   : per-slave chip selects (low)   sRdy_ : per-slave ready (low)
//   busy   : high whenever not IDLE
// Optional feature: define BUS_TIMEOUT_EN to abandon a SEL after TIMEOUT_CYC
// cycles with an error completion.
module bus_slave_sel
   import bus_slave_sel_pkg::*;
#(
   parameter int SLAVE_NUM   = SLAVE_NUM_DEF,
   parameter int ADDR_W      = 30,
   parameter int INDEX_W     = INDEX_W_DEF,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 mReq_,
   input  logic [ADDR_W-1:0]    mAddr,
   output logic                 mRdy_,
   output logic                 mErr,
   output logic [SLAVE_NUM-1:0] sCS_,
   input  logic [SLAVE_NUM-1:0] sRdy_,
   output logic                 busy
);

   if (SLAVE_NUM < 2 || SLAVE_NUM > 16 || (1 << INDEX_W) < SLAVE_NUM ||
       TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_cfg
      $error("bus_slave_sel: illegal parameter combination");
   end

   bus_state_e           state_q, state_d;
   logic [SLAVE_NUM-1:0] cs_q, cs_d;
   logic                 rdy_q, rdy_d;
   logic                 err_q, err_d;
   logic                 busy_q, busy_d;
   logic [INDEX_W-1:0]   req_idx;
   logic                 sel_rdy;
   logic                 tmo;
   logic                 unused_addr;

   assign req_idx     = mAddr[ADDR_W-1 -: INDEX_W];
   assign unused_addr = ^mAddr[ADDR_W-INDEX_W-1:0];

   // The registered select mask doubles as the latched index: only the
   // ready of the slave currently driven low can complete the transfer.
   assign sel_rdy = |(~sRdy_ & ~cs_q);

`ifdef BUS_TIMEOUT_EN
   bus_sel_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .run_i    (state_q == ST_SEL),
      .expire_o (tmo)
   );
`else
   assign tmo = 1'b0;
`endif

   // Next-state and next-output logic; every output is the registered
   // image of the state being entered.
   always_comb begin
      state_d = state_q;
      cs_d    = {SLAVE_NUM{DISABLE_}};
      rdy_d   = DISABLE_;
      err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (mReq_ == ENABLE_) begin
               if (int'(req_idx) < SLAVE_NUM) begin
                  state_d = ST_SEL;
                  for (int i = 0; i < SLAVE_NUM; i++)
                     if (req_idx == INDEX_W'(i)) cs_d[i] = ENABLE_;
               end else begin
                  state_d = ST_DONE;
                  rdy_d   = ENABLE_;
                  err_d   = 1'b1;
               end
            end
         end
         ST_SEL: begin
            // Priority: abort, then ready, then timeout.
            if (mReq_ == DISABLE_) begin
               state_d = ST_IDLE;
            end else if (sel_rdy) begin
               state_d = ST_DONE;
               rdy_d   = ENABLE_;
            end else if (tmo) begin
               state_d = ST_DONE;
               rdy_d   = ENABLE_;
               err_d   = 1'b1;
            end else begin
               cs_d = cs_q;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cs_q    <= {SLAVE_NUM{DISABLE_}};
         rdy_q   <= DISABLE_;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cs_q    <= cs_d;
         rdy_q   <= rdy_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end

   assign sCS_  = cs_q;
   assign mRdy_ = rdy_q;
   assign mErr  = err_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_bus_slave_sel.sv
module tb_bus_slave_sel;

   logic        clk = 1'b0;
   logic        reset;
   logic        mReq_;
   logic [29:0] mAddr;
   logic [7:0]  sRdy_;
   logic        mRdy_, mErr, busy;
   logic [7:0]  sCS_;

   logic        mReq6_;
   logic [29:0] mAddr6;
   logic [5:0]  sRdy6_;
   logic        mRdy6_, mErr6, busy6;
   logic [5:0]  sCS6_;

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;
   int viol = 0;
   int ovl  = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   bus_slave_sel #(.TIMEOUT_CYC(4)) dut (
      .clk(clk), .reset(reset), .mReq_(mReq_), .mAddr(mAddr), .mRdy_(mRdy_),
      .mErr(mErr), .sCS_(sCS_), .sRdy_(sRdy_), .busy(busy));

   bus_slave_sel #(.SLAVE_NUM(6)) dut6 (
      .clk(clk), .reset(reset), .mReq_(mReq6_), .mAddr(mAddr6), .mRdy_(mRdy6_),
      .mErr(mErr6), .sCS_(sCS6_), .sRdy_(sRdy6_), .busy(busy6));

   // Chip select, completion and error must never coexist.
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         if (sCS_ !== 8'hFF && mRdy_ === 1'b0) viol++;
         if (mErr === 1'b1 && mRdy_ !== 1'b0)  viol++;
         if (sCS_[1] === 1'b0 && sCS_[5] === 1'b0) ovl++;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1; mReq_ = 1'b1; mAddr = '0; sRdy_ = 8'hFF;
      mReq6_ = 1'b1; mAddr6 = '0; sRdy6_ = 6'h3F;
      tick; tick;
      reset = 1'b0;
      tick;
      nvec++; if (sCS_ !== 8'hFF) begin nerr++; $display("FAIL reset_cs got %h exp ff", sCS_); end
      nvec++; if (mRdy_ !== 1'b1) begin nerr++; $display("FAIL reset_rdy got %b exp 1", mRdy_); end
      nvec++; if (mErr !== 1'b0) begin nerr++; $display("FAIL reset_err got %b exp 0", mErr); end
      nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b exp 0", busy); end
      nvec++; if (sCS6_ !== 6'h3F) begin nerr++; $display("FAIL reset_cs6 got %h exp 3f", sCS6_); end
   endtask

   // Index 2 (address bits [29:27] = 3'b010), ready on the 3rd SEL cycle.
   task automatic test_select;
      mReq_ = 1'b0; mAddr = 30'h1000_0000;
      tick;
      nvec++; if (sCS_ !== 8'hFB) begin nerr++; $display("FAIL sel_c1 got %h exp fb", sCS_); end
      nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL sel_busy got %b exp 1", busy); end
      sRdy_ = 8'hFD;  // unselected slave 1 ready: ignored
      tick;
      nvec++; if (sCS_ !== 8'hFB) begin nerr++; $display("FAIL sel_c2 got %h exp fb", sCS_); end
      nvec++; if (mRdy_ !== 1'b1) begin nerr++; $display("FAIL sel_unsel_rdy got %b exp 1", mRdy_); end
      sRdy_ = 8'hFF;
      tick;
      nvec++; if (sCS_ !== 8'hFB) begin nerr++; $display("FAIL sel_c3 got %h exp fb", sCS_); end
      sRdy_ = 8'hFB;
      tick;
      nvec++; if ({sCS_, mRdy_, mErr} !== {8'hFF, 1'b0, 1'b0})
         begin nerr++; $display("FAIL sel_done got cs=%h rdy=%b err=%b exp ff/0/0", sCS_, mRdy_, mErr); end
      mReq_ = 1'b1; sRdy_ = 8'hFF;
      tick;
      nvec++; if ({mRdy_, busy} !== 2'b10) begin nerr++; $display("FAIL sel_idle got rdy=%b busy=%b exp 1/0", mRdy_, busy); end
   endtask

   // SLAVE_NUM=6, index 7 is unmapped.
   task automatic test_unmapped;
      mReq6_ = 1'b0; mAddr6 = 30'h3800_0000;
      tick;
      nvec++; if ({sCS6_, mRdy6_, mErr6} !== {6'h3F, 1'b0, 1'b1})
         begin nerr++; $display("FAIL unmap_done got cs=%h rdy=%b err=%b exp 3f/0/1", sCS6_, mRdy6_, mErr6); end
      mReq6_ = 1'b1;
      tick;
      nvec++; if ({sCS6_, mRdy6_, mErr6, busy6} !== {6'h3F, 1'b1, 1'b0, 1'b0})
         begin nerr++; $display("FAIL unmap_idle got cs=%h rdy=%b err=%b busy=%b exp 3f/1/0/0", sCS6_, mRdy6_, mErr6, busy6); end
   endtask

   // Index 3; TIMEOUT_CYC=4 on this instance.
   task automatic test_timeout;
`ifdef BUS_TIMEOUT_EN
      mReq_ = 1'b0; mAddr = 30'h1800_0000;
      for (int k = 1; k <= 4; k++) begin
         tick;
         nvec++; if (sCS_ !== 8'hF7) begin nerr++; $display("FAIL tmo_sel%0d got %h exp f7", k, sCS_); end
      end
      tick;
      nvec++; if ({sCS_, mRdy_, mErr} !== {8'hFF, 1'b0, 1'b1})
         begin nerr++; $display("FAIL tmo_done got cs=%h rdy=%b err=%b exp ff/0/1", sCS_, mRdy_, mErr); end
      mReq_ = 1'b1;
      tick;
      mReq_ = 1'b0;
      for (int k = 1; k <= 4; k++) tick;
      sRdy_ = 8'hF7;
      tick;
      nvec++; if ({mRdy_, mErr} !== 2'b00) begin nerr++; $display("FAIL tmo_rdy_wins got rdy=%b err=%b exp 0/0", mRdy_, mErr); end
`else
      mReq_ = 1'b0; mAddr = 30'h1800_0000;
      for (int k = 1; k <= 20; k++) tick;
      nvec++; if ({sCS_, mRdy_, busy} !== {8'hF7, 1'b1, 1'b1})
         begin nerr++; $display("FAIL notmo_wait got cs=%h rdy=%b busy=%b exp f7/1/1", sCS_, mRdy_, busy); end
      sRdy_ = 8'hF7;
      tick;
      nvec++; if ({mRdy_, mErr} !== 2'b00) begin nerr++; $display("FAIL notmo_done got rdy=%b err=%b exp 0/0", mRdy_, mErr); end
`endif
      mReq_ = 1'b1; sRdy_ = 8'hFF;
      tick;
   endtask

   // Index 4; abort in SEL cycle 2 together with ready.
   task automatic test_abort;
      mReq_ = 1'b0; mAddr = 30'h2000_0000;
      tick;
      nvec++; if (sCS_ !== 8'hEF) begin nerr++; $display("FAIL abort_sel got %h exp ef", sCS_); end
      tick;
      mReq_ = 1'b1; sRdy_ = 8'hEF;
      tick;
      nvec++; if ({sCS_, mRdy_, busy} !== {8'hFF, 1'b1, 1'b0})
         begin nerr++; $display("FAIL abort_idle got cs=%h rdy=%b busy=%b exp ff/1/0", sCS_, mRdy_, busy); end
      sRdy_ = 8'hFF;
      tick;
      nvec++; if (mRdy_ !== 1'b1) begin nerr++; $display("FAIL abort_nopulse got %b exp 1", mRdy_); end
   endtask

   // Index 6; reset mid-SEL, then the held request is accepted afresh.
   task automatic test_reset_mid;
      mReq_ = 1'b0; mAddr = 30'h3000_0000;
      tick; tick;
      reset = 1'b1;
      tick;
      nvec++; if ({sCS_, busy, mRdy_} !== {8'hFF, 1'b0, 1'b1})
         begin nerr++; $display("FAIL rstmid got cs=%h busy=%b rdy=%b exp ff/0/1", sCS_, busy, mRdy_); end
      reset = 1'b0;
      tick;
      nvec++; if (sCS_ !== 8'hBF) begin nerr++; $display("FAIL rstmid_reacc got %h exp bf", sCS_); end
      sRdy_ = 8'hBF;
      tick;
      nvec++; if ({mRdy_, mErr} !== 2'b00) begin nerr++; $display("FAIL rstmid_done got rdy=%b err=%b exp 0/0", mRdy_, mErr); end
      mReq_ = 1'b1; sRdy_ = 8'hFF;
      tick;
   endtask

   // Slaves 1 then 5 with mReq_ held low throughout.
   task automatic test_back_to_back;
      int t1, t2;
      mReq_ = 1'b0; mAddr = 30'h0800_0000;
      tick;
      nvec++; if (sCS_ !== 8'hFD) begin nerr++; $display("FAIL b2b_sel1 got %h exp fd", sCS_); end
      sRdy_ = 8'hFD;
      tick;
      t1 = cyc;
      nvec++; if (mRdy_ !== 1'b0) begin nerr++; $display("FAIL b2b_done1 got %b exp 0", mRdy_); end
      mAddr = 30'h2800_0000; sRdy_ = 8'hFF;
      tick;
      nvec++; if ({sCS_, mRdy_} !== {8'hFF, 1'b1}) begin nerr++; $display("FAIL b2b_gap got cs=%h rdy=%b exp ff/1", sCS_, mRdy_); end
      tick;
      nvec++; if (sCS_ !== 8'hDF) begin nerr++; $display("FAIL b2b_sel5 got %h exp df", sCS_); end
      sRdy_ = 8'hDF;
      tick;
      t2 = cyc;
      nvec++; if ({mRdy_, mErr} !== 2'b00) begin nerr++; $display("FAIL b2b_done2 got rdy=%b err=%b exp 0/0", mRdy_, mErr); end
      nvec++; if (t2 - t1 < 3) begin nerr++; $display("FAIL b2b_spacing got %0d exp >=3", t2 - t1); end
      mReq_ = 1'b1; sRdy_ = 8'hFF;
      tick;
   endtask

   initial begin
      test_reset;
      test_select;
      test_unmapped;
      test_timeout;
      test_abort;
      test_reset_mid;
      test_back_to_back;
      tick;
      nvec++; if (ovl !== 0) begin nerr++; $display("FAIL cs_overlap got %0d exp 0", ovl); end
      nvec++; if (viol !== 0) begin nerr++; $display("FAIL exclusive_outputs got %0d exp 0", viol); end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
